// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
//
// Shared definitions for the systolic matrix-multiply sequencer, the MMU and
// the weight memory.
//
// Contents:
//   DIM_MIN / DIM_MAX : legal range of the array dimension DIM
//   state_e           : sequencer states (IDLE, LOAD, COMPUTE)
//   clog2()           : constant function used to size address and cycle
//                       counters from DIM
// ---------------------------------------------------------------------------
package tpu_pkg;

    localparam int DIM_MIN = 2;
    localparam int DIM_MAX = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2
    } state_e;

    // Ceiling log2, with clog2(1) = 0. It is evaluated at elaboration time
    // to size the counters.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tpu_sequencer.sv
// ---------------------------------------------------------------------------
// tpu_sequencer
//
// Top-level sequencer for a DIM x DIM systolic matrix-multiply datapath.
// The sequencer works in two phases:
//   1. It loads activation matrix A, and optionally weight matrix B, from the
//      host into weight memory, one element at a time.
//   2. It opens the MMU compute window for COMP_CYC cycles.
// B stays resident across runs. A run started with keep_weights reloads only
// A, provided that a complete B load has happened since the last reset or
// abort.
//
// Ports:
//   clk, rst_n     : clock (rising edge) and asynchronous active-low reset
//   start          : begin a run; honoured only in IDLE
//   keep_weights   : sampled with start; reuse the resident B if it is valid
//   abort          : synchronous return to IDLE from any state
//   host_valid     : host presents an element this cycle
//   host_req_mat   : sequencer is requesting elements (LOAD state)
//   wm_load_mat    : weight-memory write strobe
//   wm_addr        : element address (A at 0..N_ELEM-1, B above it)
//   feeding_en     : MMU feed enable for the whole compute window
//   mmu_cycles     : cycle index inside the compute window
//   busy           : sequencer is not in IDLE
//   done           : one-cycle pulse after a run completes normally
// ---------------------------------------------------------------------------
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter  int DIM      = 2,
    localparam int N_ELEM   = DIM * DIM,
    localparam int ADDR_W   = clog2(2 * N_ELEM),
    localparam int COMP_CYC = N_ELEM + 2,
    localparam int CYC_W    = clog2(COMP_CYC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              keep_weights,
    input  logic              abort,
    input  logic              host_valid,
    output logic              host_req_mat,
    output logic              wm_load_mat,
    output logic [ADDR_W-1:0] wm_addr,
    output logic              feeding_en,
    output logic [CYC_W-1:0]  mmu_cycles,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(N_ELEM - 1);
    localparam logic [ADDR_W-1:0] LAST_B   = ADDR_W'(2 * N_ELEM - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(COMP_CYC - 1);

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] elem_cnt_q,  elem_cnt_d;
    logic [ADDR_W-1:0] load_last_q, load_last_d;
    logic [CYC_W-1:0]  cyc_cnt_q,   cyc_cnt_d;
    logic              w_valid_q,   w_valid_d;
    logic              done_q,      done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            elem_cnt_q  <= '0;
            load_last_q <= '0;
            cyc_cnt_q   <= '0;
            w_valid_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            load_last_q <= load_last_d;
            cyc_cnt_q   <= cyc_cnt_d;
            w_valid_q   <= w_valid_d;
            done_q      <= done_d;
        end
    end

    // Both counters are returned to zero whenever their state is left. As a
    // result, wm_addr and mmu_cycles can come straight from the flops and
    // still read 0 outside LOAD and COMPUTE.
    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        load_last_d = load_last_q;
        cyc_cnt_d   = cyc_cnt_q;
        w_valid_d   = w_valid_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                elem_cnt_d = '0;
                cyc_cnt_d  = '0;
                if (start) begin
                    state_d     = LOAD;
                    load_last_d = (keep_weights && w_valid_q) ? LAST_A : LAST_B;
                end
            end
            LOAD: begin
                if (host_valid) begin
                    if (elem_cnt_q == load_last_q) begin
                        state_d    = COMPUTE;
                        elem_cnt_d = '0;
                        cyc_cnt_d  = '0;
                        // An A-only load ends at LAST_A. Only a full load
                        // reaches this address, so only a full load marks B
                        // as resident.
                        if (elem_cnt_q == LAST_B) begin
                            w_valid_d = 1'b1;
                        end
                    end else begin
                        elem_cnt_d = elem_cnt_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (cyc_cnt_q == CYC_LAST) begin
                    state_d   = IDLE;
                    cyc_cnt_d = '0;
                    done_d    = 1'b1;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides every transition, including the final load
        // transfer and the last compute cycle. B can no longer be trusted
        // after an abort.
        if (abort) begin
            state_d    = IDLE;
            elem_cnt_d = '0;
            cyc_cnt_d  = '0;
            w_valid_d  = 1'b0;
            done_d     = 1'b0;
        end
    end

    // The write strobe is combinational on host_valid. An element offered in
    // the same cycle as abort is therefore still written to memory, but the
    // sequencer ignores it.
    assign host_req_mat = (state_q == LOAD);
    assign wm_load_mat  = host_req_mat & host_valid;
    assign wm_addr      = elem_cnt_q;
    assign feeding_en   = (state_q == COMPUTE);
    assign mmu_cycles   = cyc_cnt_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tpu_sequencer
//
// Directed bench for tpu_sequencer. Two instances share the clock and reset:
// u_dut2 (DIM=2) and u_dut3 (DIM=3). Inputs change 1 time unit after the
// rising edge. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_tpu_sequencer;

    logic       clk;
    logic       rst_n;

    logic       start2, keep2, abort2, hv2;
    logic       req2, load2, feed2, busy2, done2;
    logic [2:0] addr2;
    logic [2:0] cyc2;

    logic       start3, keep3, abort3, hv3;
    logic       req3, load3, feed3, busy3, done3;
    logic [4:0] addr3;
    logic [3:0] cyc3;

    int vec_count;
    int err_count;

    tpu_sequencer #(.DIM(2)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start2),
        .keep_weights (keep2),
        .abort        (abort2),
        .host_valid   (hv2),
        .host_req_mat (req2),
        .wm_load_mat  (load2),
        .wm_addr      (addr2),
        .feeding_en   (feed2),
        .mmu_cycles   (cyc2),
        .busy         (busy2),
        .done         (done2)
    );

    tpu_sequencer #(.DIM(3)) u_dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start3),
        .keep_weights (keep3),
        .abort        (abort3),
        .host_valid   (hv3),
        .host_req_mat (req3),
        .wm_load_mat  (load3),
        .wm_addr      (addr3),
        .feeding_en   (feed3),
        .mmu_cycles   (cyc3),
        .busy         (busy3),
        .done         (done3)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        vec_count++;
        if ({req2, load2, addr2, feed2, cyc2, busy2, done2} !== 11'd0) begin
            err_count++;
            $display("[TB] FAIL reset_dim2: got %b expected all zero",
                     {req2, load2, addr2, feed2, cyc2, busy2, done2});
        end
        vec_count++;
        if ({req3, load3, addr3, feed3, cyc3, busy3, done3} !== 14'd0) begin
            err_count++;
            $display("[TB] FAIL reset_dim3: got %b expected all zero",
                     {req3, load3, addr3, feed3, cyc3, busy3, done3});
        end
        tick();
        rst_n = 1'b1;
    endtask

    // DIM=2 full load with host_valid held high. Expected: addresses 0..7
    // on consecutive cycles, then 6 compute cycles, then one done pulse.
    task automatic test_full_load;
        start2 = 1'b1; keep2 = 1'b0; hv2 = 1'b1;
        @(negedge clk);
        vec_count++;
        if (busy2 !== 1'b0) begin
            err_count++;
            $display("[TB] FAIL full_idle_busy: got %b expected 0", busy2);
        end
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vec_count++;
            if ({req2, load2, feed2, addr2} !== {1'b1, 1'b1, 1'b0, 3'(k)}) begin
                err_count++;
                $display("[TB] FAIL full_load_k%0d: got req=%b ld=%b feed=%b addr=%0d expected 1 1 0 %0d",
                         k, req2, load2, feed2, addr2, k);
            end
            tick();
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vec_count++;
            if ({feed2, cyc2, req2, load2, addr2, busy2, done2} !== {1'b1, 3'(c), 1'b0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
                err_count++;
                $display("[TB] FAIL full_comp_c%0d: got feed=%b cyc=%0d req=%b ld=%b addr=%0d busy=%b done=%b expected 1 %0d 0 0 0 1 0",
                         c, feed2, cyc2, req2, load2, addr2, busy2, done2, c);
            end
            tick();
        end
        @(negedge clk);
        vec_count++;
        if ({done2, busy2, feed2, cyc2} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            err_count++;
            $display("[TB] FAIL full_done: got done=%b busy=%b feed=%b cyc=%0d expected 1 0 0 0",
                     done2, busy2, feed2, cyc2);
        end
        hv2 = 1'b0;
        tick();
        @(negedge clk);
        vec_count++;
        if ({done2, busy2} !== 2'b00) begin
            err_count++;
            $display("[TB] FAIL full_after_done: got done=%b busy=%b expected 0 0", done2, busy2);
        end
        tick();
    endtask

    // DIM=3 with host_valid cycling 1,0,0. Expected: 18 writes, each at the
    // next address, then an 11-cycle compute window.
    task automatic test_stalled_host;
        int writes;
        int obs_writes;
        int i;
        writes = 0;
        obs_writes = 0;
        i = 0;
        start3 = 1'b1; keep3 = 1'b0; hv3 = 1'b0;
        tick();
        start3 = 1'b0;
        while (writes < 18 && i < 100) begin
            hv3 = (i % 3 == 0);
            @(negedge clk);
            vec_count++;
            if ({req3, load3, addr3} !== {1'b1, hv3, 5'(writes)}) begin
                err_count++;
                $display("[TB] FAIL stall_i%0d: got req=%b ld=%b addr=%0d expected 1 %b %0d",
                         i, req3, load3, addr3, hv3, writes);
            end
            if (load3 === 1'b1) obs_writes++;
            if (hv3) writes++;
            tick();
            i++;
        end
        hv3 = 1'b0;
        vec_count++;
        if (obs_writes !== 18) begin
            err_count++;
            $display("[TB] FAIL stall_write_count: got %0d expected 18", obs_writes);
        end
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            vec_count++;
            if ({feed3, cyc3, req3} !== {1'b1, 4'(c), 1'b0}) begin
                err_count++;
                $display("[TB] FAIL stall_comp_c%0d: got feed=%b cyc=%0d req=%b expected 1 %0d 0",
                         c, feed3, cyc3, req3, c);
            end
            tick();
        end
        @(negedge clk);
        vec_count++;
        if ({done3, feed3, busy3} !== 3'b100) begin
            err_count++;
            $display("[TB] FAIL stall_done: got done=%b feed=%b busy=%b expected 1 0 0",
                     done3, feed3, busy3);
        end
        tick();
    endtask

    task automatic test_weight_reuse;
        // One full DIM=2 run makes B resident.
        start2 = 1'b1; keep2 = 1'b0; hv2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (14) tick();
        // This is the done cycle: start an A-only run.
        start2 = 1'b1; keep2 = 1'b1;
        tick();
        start2 = 1'b0; keep2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vec_count++;
            if ({req2, load2, addr2} !== {1'b1, 1'b1, 3'(k)}) begin
                err_count++;
                $display("[TB] FAIL reuse_k%0d: got req=%b ld=%b addr=%0d expected 1 1 %0d",
                         k, req2, load2, addr2, k);
            end
            tick();
        end
        @(negedge clk);
        vec_count++;
        if ({feed2, cyc2, req2} !== {1'b1, 3'd0, 1'b0}) begin
            err_count++;
            $display("[TB] FAIL reuse_compute: got feed=%b cyc=%0d req=%b expected 1 0 0",
                     feed2, cyc2, req2);
        end
        // An abort clears w_valid, so the next keep_weights run must load
        // all 8 elements.
        tick();
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        start2 = 1'b1; keep2 = 1'b1;
        tick();
        start2 = 1'b0; keep2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vec_count++;
            if ({req2, feed2, addr2} !== {1'b1, 1'b0, 3'(k)}) begin
                err_count++;
                $display("[TB] FAIL reuse_after_abort_k%0d: got req=%b feed=%b addr=%0d expected 1 0 %0d",
                         k, req2, feed2, addr2, k);
            end
            tick();
        end
        @(negedge clk);
        vec_count++;
        if (feed2 !== 1'b1) begin
            err_count++;
            $display("[TB] FAIL reuse_after_abort_compute: got feed=%b expected 1", feed2);
        end
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0; hv2 = 1'b0;
        tick();
    endtask

    task automatic test_abort;
        // Abort at address 5 while host_valid is high.
        start2 = 1'b1; keep2 = 1'b0; hv2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (5) tick();
        abort2 = 1'b1;
        @(negedge clk);
        vec_count++;
        if ({addr2, load2} !== {3'd5, 1'b1}) begin
            err_count++;
            $display("[TB] FAIL abort_load_strobe: got addr=%0d ld=%b expected 5 1", addr2, load2);
        end
        tick();
        abort2 = 1'b0; hv2 = 1'b0;
        @(negedge clk);
        vec_count++;
        if ({req2, load2, addr2, feed2, cyc2, busy2, done2} !== 11'd0) begin
            err_count++;
            $display("[TB] FAIL abort_load_idle: got %b expected all zero",
                     {req2, load2, addr2, feed2, cyc2, busy2, done2});
        end
        tick();
        @(negedge clk);
        vec_count++;
        if (done2 !== 1'b0) begin
            err_count++;
            $display("[TB] FAIL abort_load_no_done: got %b expected 0", done2);
        end
        tick();
        // Abort on the last compute cycle.
        start2 = 1'b1; hv2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (13) tick();
        abort2 = 1'b1;
        @(negedge clk);
        vec_count++;
        if ({feed2, cyc2} !== {1'b1, 3'd5}) begin
            err_count++;
            $display("[TB] FAIL abort_comp_pre: got feed=%b cyc=%0d expected 1 5", feed2, cyc2);
        end
        tick();
        abort2 = 1'b0; hv2 = 1'b0;
        @(negedge clk);
        vec_count++;
        if ({req2, load2, addr2, feed2, cyc2, busy2, done2} !== 11'd0) begin
            err_count++;
            $display("[TB] FAIL abort_comp_idle: got %b expected all zero",
                     {req2, load2, addr2, feed2, cyc2, busy2, done2});
        end
        tick();
        @(negedge clk);
        vec_count++;
        if (done2 !== 1'b0) begin
            err_count++;
            $display("[TB] FAIL abort_comp_no_done: got %b expected 0", done2);
        end
        tick();
    endtask

    task automatic test_start_during_busy;
        int done_seen;
        done_seen = 0;
        start2 = 1'b1; keep2 = 1'b0; hv2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            start2 = (k == 3);
            @(negedge clk);
            if (done2 === 1'b1) done_seen++;
            vec_count++;
            if (addr2 !== 3'(k)) begin
                err_count++;
                $display("[TB] FAIL busy_load_k%0d: got addr=%0d expected %0d", k, addr2, k);
            end
            tick();
        end
        for (int c = 0; c < 6; c++) begin
            start2 = (c == 2);
            keep2  = (c == 2);
            @(negedge clk);
            if (done2 === 1'b1) done_seen++;
            vec_count++;
            if (cyc2 !== 3'(c)) begin
                err_count++;
                $display("[TB] FAIL busy_comp_c%0d: got cyc=%0d expected %0d", c, cyc2, c);
            end
            tick();
        end
        keep2 = 1'b0;
        // This is the done cycle. A start here must be accepted.
        start2 = 1'b1;
        @(negedge clk);
        if (done2 === 1'b1) done_seen++;
        vec_count++;
        if (done_seen !== 1) begin
            err_count++;
            $display("[TB] FAIL busy_done_count: got %0d expected 1", done_seen);
        end
        tick();
        start2 = 1'b0;
        @(negedge clk);
        vec_count++;
        if ({req2, addr2, busy2, done2} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
            err_count++;
            $display("[TB] FAIL busy_b2b_start: got req=%b addr=%0d busy=%b done=%b expected 1 0 1 0",
                     req2, addr2, busy2, done2);
        end
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0; hv2 = 1'b0;
        tick();
    endtask

    task automatic test_async_reset;
        start2 = 1'b1; keep2 = 1'b0; hv2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (11) tick();
        @(negedge clk);
        vec_count++;
        if ({feed2, cyc2} !== {1'b1, 3'd3}) begin
            err_count++;
            $display("[TB] FAIL areset_pre: got feed=%b cyc=%0d expected 1 3", feed2, cyc2);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vec_count++;
        if ({req2, load2, addr2, feed2, cyc2, busy2, done2} !== 11'd0) begin
            err_count++;
            $display("[TB] FAIL areset_immediate: got %b expected all zero",
                     {req2, load2, addr2, feed2, cyc2, busy2, done2});
        end
        tick();
        rst_n = 1'b1;
        // Reset cleared w_valid, so a keep_weights start must reload B too.
        start2 = 1'b1; keep2 = 1'b1;
        tick();
        start2 = 1'b0; keep2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vec_count++;
            if ({req2, feed2, addr2} !== {1'b1, 1'b0, 3'(k)}) begin
                err_count++;
                $display("[TB] FAIL areset_full_k%0d: got req=%b feed=%b addr=%0d expected 1 0 %0d",
                         k, req2, feed2, addr2, k);
            end
            tick();
        end
        @(negedge clk);
        vec_count++;
        if (feed2 !== 1'b1) begin
            err_count++;
            $display("[TB] FAIL areset_full_compute: got feed=%b expected 1", feed2);
        end
        tick();
        hv2 = 1'b0;
    endtask

    // Run the scenarios in order, then report.
    initial begin
        vec_count = 0;
        err_count = 0;
        rst_n  = 1'b0;
        start2 = 1'b0; keep2 = 1'b0; abort2 = 1'b0; hv2 = 1'b0;
        start3 = 1'b0; keep3 = 1'b0; abort3 = 1'b0; hv3 = 1'b0;

        test_reset();
        test_full_load();
        test_stalled_host();
        test_weight_reuse();
        test_abort();
        test_start_during_busy();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
